mc_pred_sched: RTL and testbench

//  Macroblock-level scheduler wrapped around the MC core. Accepts one MB job (type + MVs) from the pipeline

---
 rtl/mc_pred_sched_pkg.sv | 24 ++
 rtl/mc_pred_bank.sv | 32 +++
 rtl/mc_pred_sched.sv | 142 ++++++++++++++
 tb/tb_mc_pred_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pred_sched_pkg.sv
// Shared widths and FSM encoding for the MC prediction scheduler.
// Values mirror the encoder-wide defines so the scheduler can be built standalone.
package mc_pred_sched_pkg;

  localparam int BLK4X4_NUM    = 16;
  localparam int FMVD_LEN      = 2;
  localparam int IMVD_LEN      = 7;
  localparam int MB_TYPE_LEN   = 15;
  localparam int FMV_W         = BLK4X4_NUM * 2 * FMVD_LEN;
  localparam int IMV_W         = BLK4X4_NUM * 2 * IMVD_LEN;
  localparam int DEF_BIT_DEPTH = 8;
  localparam int DEF_NBEAT     = 12;
  localparam int DEF_DRAIN_MAX = 8;
  localparam int BEAT_AW       = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_COMMIT = 3'd4
  } sched_state_e;

endpackage

// File: rtl/mc_pred_bank.sv
// Ping-pong prediction store: two banks of NBEAT beats, one write port, one registered read port.
// Kept as a plain array so it can be replaced by an SRAM macro with the same timing.
module mc_pred_bank #(
  parameter int BEAT_W = 256,
  parameter int NBEAT  = 12,
  parameter int AW     = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [BEAT_W-1:0] rd_data
);

  logic [BEAT_W-1:0] mem [2][NBEAT];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  // read stage: data appears one cycle after rd_en
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/mc_pred_sched.sv
// MB-level scheduler around the MC core: launches one job, collects its prediction beats into a
// ping-pong bank and hands completed banks to TQ so MC of MB n+1 overlaps TQ of MB n.
module mc_pred_sched
  import mc_pred_sched_pkg::*;
#(
  parameter  int BIT_DEPTH = DEF_BIT_DEPTH,
  parameter  int NBEAT     = DEF_NBEAT,
  parameter  int DRAIN_MAX = DEF_DRAIN_MAX,
  localparam int BEAT_W    = 32 * BIT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   mb_start_i,
  input  logic [MB_TYPE_LEN-1:0] mb_type_info_i,
  input  logic [FMV_W-1:0]       fmv_i,
  input  logic [IMV_W-1:0]       imv_i,
  output logic                   mb_ready_o,
  output logic                   start_mc_o,
  output logic [MB_TYPE_LEN-1:0] mb_type_info_o,
  output logic [FMV_W-1:0]       fmv_o,
  output logic [IMV_W-1:0]       imv_o,
  input  logic                   done_mc_i,
  input  logic                   mc_pred_rdy_i,
  input  logic [BEAT_AW-1:0]     mc_pred_addr_i,
  input  logic [BEAT_W-1:0]      mc_pred_data_i,
  output logic                   tq_rdy_o,
  input  logic                   tq_rden_i,
  input  logic [BEAT_AW-1:0]     tq_addr_i,
  output logic [BEAT_W-1:0]      tq_data_o,
  output logic                   tq_valid_o,
  input  logic                   tq_done_i,
  output logic                   err_o
);

  localparam int                 CNT_W     = $clog2(DRAIN_MAX + 1);
  localparam logic [BEAT_AW-1:0] LAST_ADDR = BEAT_AW'(NBEAT - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DRAIN_MAX - 1);

  sched_state_e     state_q, state_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       full_q, full_d;
  logic [NBEAT-1:0] mask_q, mask_d, beat_bit;
  logic [CNT_W-1:0] drain_cnt_q;
  logic             err_q, err_d;
  logic             tq_valid_p1;
  logic             accept, in_window, addr_ok, beat_wr, mask_full;
  logic             commit, release_bank, drain_timeout, beat_bad, done_bad;

  // Gated by reset so the pipeline never sees a ready while the scheduler is held in reset.
  assign mb_ready_o    = rst_n_i & (state_q == ST_IDLE) & ~full_q[wr_ptr_q];
  assign accept        = mb_start_i & mb_ready_o;
  assign in_window     = state_q inside {ST_RUN, ST_DRAIN, ST_COMMIT};
  assign addr_ok       = (mc_pred_addr_i <= LAST_ADDR);
  assign beat_wr       = mc_pred_rdy_i & addr_ok & in_window;
  assign beat_bit      = beat_wr ? (NBEAT'(1) << mc_pred_addr_i) : '0;
  assign mask_d        = mask_q | beat_bit;
  assign mask_full     = &mask_d;
  assign commit        = (state_q == ST_COMMIT);
  assign release_bank  = tq_done_i & full_q[rd_ptr_q];
  assign drain_timeout = (state_q == ST_DRAIN) & ~mask_full & (drain_cnt_q == CNT_LAST);
  assign beat_bad      = mc_pred_rdy_i & (~addr_ok | (state_q inside {ST_IDLE, ST_LAUNCH}));
  assign done_bad      = done_mc_i & (state_q != ST_RUN);

  assign start_mc_o = (state_q == ST_LAUNCH);
  assign tq_rdy_o   = full_q[rd_ptr_q];
  assign tq_valid_o = tq_valid_p1;
  assign err_o      = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN:    if (done_mc_i) state_d = mask_full ? ST_COMMIT : ST_DRAIN;
      ST_DRAIN:  if (mask_full || drain_timeout) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Commit and release always address different banks, so both updates can land together.
  always_comb begin
    full_d = full_q;
    if (commit)       full_d[wr_ptr_q] = 1'b1;
    if (release_bank) full_d[rd_ptr_q] = 1'b0;
  end

  assign err_d = err_q | beat_bad | done_bad | drain_timeout | (tq_rden_i & ~tq_rdy_o);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      full_q      <= '0;
      mask_q      <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
      tq_valid_p1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      err_q       <= err_d;
      tq_valid_p1 <= tq_rden_i;
      mask_q      <= accept ? '0 : mask_d;
      drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + CNT_W'(1) : '0;
      if (commit)       wr_ptr_q <= ~wr_ptr_q;
      if (release_bank) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Job descriptor held from launch until the next accepted job.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mb_type_info_o <= '0;
      fmv_o          <= '0;
      imv_o          <= '0;
    end else if (accept) begin
      mb_type_info_o <= mb_type_info_i;
      fmv_o          <= fmv_i;
      imv_o          <= imv_i;
    end
  end

  mc_pred_bank #(
    .BEAT_W (BEAT_W),
    .NBEAT  (NBEAT),
    .AW     (BEAT_AW)
  ) u_bank (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_en   (beat_wr),
    .wr_bank (wr_ptr_q),
    .wr_addr (mc_pred_addr_i),
    .wr_data (mc_pred_data_i),
    .rd_en   (tq_rden_i & (tq_addr_i <= LAST_ADDR)),
    .rd_bank (rd_ptr_q),
    .rd_addr (tq_addr_i),
    .rd_data (tq_data_o)
  );

endmodule

// File: tb/tb_mc_pred_sched.sv
// Bench for mc_pred_sched: table-driven single-MB run plus hand-written multi-cycle sequences,
// with TQ read data checked against a scoreboard of expected beats.
module tb_mc_pred_sched;
  import mc_pred_sched_pkg::*;

  localparam int BW = 256;

  logic                   clk_i = 1'b0;
  logic                   rst_n_i = 1'b0;
  logic                   mb_start_i;
  logic [MB_TYPE_LEN-1:0] mb_type_info_i;
  logic [FMV_W-1:0]       fmv_i;
  logic [IMV_W-1:0]       imv_i;
  logic                   mb_ready_o;
  logic                   start_mc_o;
  logic [MB_TYPE_LEN-1:0] mb_type_info_o;
  logic [FMV_W-1:0]       fmv_o;
  logic [IMV_W-1:0]       imv_o;
  logic                   done_mc_i;
  logic                   mc_pred_rdy_i;
  logic [BEAT_AW-1:0]     mc_pred_addr_i;
  logic [BW-1:0]          mc_pred_data_i;
  logic                   tq_rdy_o;
  logic                   tq_rden_i;
  logic [BEAT_AW-1:0]     tq_addr_i;
  logic [BW-1:0]          tq_data_o;
  logic                   tq_valid_o;
  logic                   tq_done_i;
  logic                   err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [BW-1:0]          sb_q[$];
  logic [BW-1:0]          sb_exp;
  logic [MB_TYPE_LEN-1:0] exp_info;
  logic [FMV_W-1:0]       exp_fmv;
  logic [IMV_W-1:0]       exp_imv;

  typedef struct {
    logic       rdy;
    logic [3:0] addr;
    logic       done;
    logic       e_err;
    logic       e_tqrdy;
    logic       e_ready;
  } vec_t;
  vec_t vt[16];

  mc_pred_sched dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .mb_start_i     (mb_start_i),
    .mb_type_info_i (mb_type_info_i),
    .fmv_i          (fmv_i),
    .imv_i          (imv_i),
    .mb_ready_o     (mb_ready_o),
    .start_mc_o     (start_mc_o),
    .mb_type_info_o (mb_type_info_o),
    .fmv_o          (fmv_o),
    .imv_o          (imv_o),
    .done_mc_i      (done_mc_i),
    .mc_pred_rdy_i  (mc_pred_rdy_i),
    .mc_pred_addr_i (mc_pred_addr_i),
    .mc_pred_data_i (mc_pred_data_i),
    .tq_rdy_o       (tq_rdy_o),
    .tq_rden_i      (tq_rden_i),
    .tq_addr_i      (tq_addr_i),
    .tq_data_o      (tq_data_o),
    .tq_valid_o     (tq_valid_o),
    .tq_done_i      (tq_done_i),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [BW-1:0] beat(input int mb, input int a);
    logic [31:0] w;
    w = {8'(mb), 8'(a), 16'hC0DE ^ 16'(mb * 37 + a)};
    return {8{w}};
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!mb_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!mb_ready_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: mb_ready_o still 0 after 50 cycles, expected 1", name);
    end
  endtask

  task automatic wait_tqrdy(input string name);
    int n = 0;
    while (!tq_rdy_o && n < 20) begin
      tick();
      n++;
    end
    if (!tq_rdy_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: tq_rdy_o still 0 after 20 cycles, expected 1", name);
    end
  endtask

  task automatic send_job(input int mb);
    wait_ready($sformatf("job%0d_ready", mb));
    exp_info       = 15'(mb * 4097 + 3);
    exp_fmv        = {32'(mb * 12345 + 1), 32'(mb ^ 32'h5A5A)};
    exp_imv        = {7{32'(mb * 7919 + 11)}};
    mb_type_info_i = exp_info;
    fmv_i          = exp_fmv;
    imv_i          = exp_imv;
    mb_start_i     = 1'b1;
    tick();
    mb_start_i     = 1'b0;
    mb_type_info_i = ~exp_info;
    fmv_i          = ~exp_fmv;
    imv_i          = ~exp_imv;
    check1($sformatf("job%0d_start_pulse", mb), start_mc_o, 1'b1);
    tick();
    check1($sformatf("job%0d_start_once", mb), start_mc_o, 1'b0);
  endtask

  task automatic beat_cycle(input int mb, input int a, input logic rdy, input logic done);
    mc_pred_rdy_i  = rdy;
    mc_pred_addr_i = 4'(a);
    mc_pred_data_i = beat(mb, a);
    done_mc_i      = done;
    tick();
    mc_pred_rdy_i  = 1'b0;
    done_mc_i      = 1'b0;
  endtask

  task automatic run_full(input int mb);
    for (int a = 0; a < 12; a++) beat_cycle(mb, a, 1'b1, a == 11);
  endtask

  task automatic tq_read(input string name, input int a, input logic [BW-1:0] exp);
    tq_rden_i = 1'b1;
    tq_addr_i = 4'(a);
    sb_q.push_back(exp);
    tick();
    tq_rden_i = 1'b0;
    check1({name, "_valid"}, tq_valid_o, 1'b1);
    tick();
  endtask

  task automatic pulse_tq_done();
    tq_done_i = 1'b1;
    tick();
    tq_done_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i && tq_valid_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: tq_valid_o=1 with no read outstanding, data %0h", tq_data_o);
      end else begin
        sb_exp = sb_q.pop_front();
        checkw("sb_tq_data", tq_data_o, sb_exp);
      end
    end
  end

  initial begin
    mb_start_i = 0; mb_type_info_i = '0; fmv_i = '0; imv_i = '0;
    done_mc_i = 0; mc_pred_rdy_i = 0; mc_pred_addr_i = '0; mc_pred_data_i = '0;
    tq_rden_i = 0; tq_addr_i = '0; tq_done_i = 0;

    // single MB: luma beats, done, chroma trailing over five cycles, two idle cycles
    for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    vt[15] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk_i);
    #1;
    check1("rst_mb_ready", mb_ready_o, 1'b0);
    check1("rst_start_mc", start_mc_o, 1'b0);
    check1("rst_tq_rdy", tq_rdy_o, 1'b0);
    check1("rst_tq_valid", tq_valid_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    checkw("rst_tq_data", tq_data_o, '0);
    rst_n_i = 1'b1;
    tick();
    check1("post_rst_mb_ready", mb_ready_o, 1'b1);

    // single MB through the table
    send_job(1);
    for (int i = 0; i < 16; i++) begin
      beat_cycle(1, int'(vt[i].addr), vt[i].rdy, vt[i].done);
      check1($sformatf("t1_err[%0d]", i), err_o, vt[i].e_err);
      check1($sformatf("t1_tq_rdy[%0d]", i), tq_rdy_o, vt[i].e_tqrdy);
      check1($sformatf("t1_mb_ready[%0d]", i), mb_ready_o, vt[i].e_ready);
    end
    checkw("t1_info_latched", BW'(mb_type_info_o), BW'(exp_info));
    checkw("t1_fmv_latched", BW'(fmv_o), BW'(exp_fmv));
    checkw("t1_imv_latched", BW'(imv_o), BW'(exp_imv));
    tq_read("t1_rd10", 10, beat(1, 10));

    // back-to-back: second MB fills the other bank, third start must be ignored
    send_job(2);
    run_full(2);
    tick();
    check1("t2_both_full_ready", mb_ready_o, 1'b0);
    check1("t2_tq_rdy", tq_rdy_o, 1'b1);
    mb_start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1($sformatf("t2_third_start_ignored[%0d]", i), start_mc_o, 1'b0);
    end
    mb_start_i = 1'b0;
    check1("t2_still_stalled", mb_ready_o, 1'b0);
    pulse_tq_done();
    check1("t2_ready_after_release", mb_ready_o, 1'b1);
    check1("t2_mb1_bank_rdy", tq_rdy_o, 1'b1);
    tq_read("t2_rd3", 3, beat(2, 3));

    // overlap: release bank1 in the same cycle bank0 commits
    send_job(3);
    run_full(3);
    pulse_tq_done();
    check1("t4_tq_rdy", tq_rdy_o, 1'b1);
    check1("t4_mb_ready", mb_ready_o, 1'b1);
    tq_read("t4_rd5", 5, beat(3, 5));
    pulse_tq_done();
    check1("t4_all_released", tq_rdy_o, 1'b0);
    check1("t4_no_err", err_o, 1'b0);

    // truncated MB: addr 11 never arrives
    send_job(4);
    for (int a = 0; a < 11; a++) beat_cycle(4, a, 1'b1, 1'b0);
    beat_cycle(0, 0, 1'b0, 1'b1);
    repeat (5) tick();
    check1("t3_no_err_5", err_o, 1'b0);
    repeat (2) tick();
    check1("t3_no_err_7", err_o, 1'b0);
    tick();
    check1("t3_err_timeout", err_o, 1'b1);
    tick();
    check1("t3_tq_rdy", tq_rdy_o, 1'b1);
    tq_read("t3_rd4", 4, beat(4, 4));
    tq_read("t3_rd11_stale", 11, beat(2, 11));

    // reset in RUN after five beats
    send_job(7);
    for (int a = 0; a < 5; a++) beat_cycle(7, a, 1'b1, 1'b0);
    #3 rst_n_i = 1'b0;
    #1;
    check1("t6_mb_ready", mb_ready_o, 1'b0);
    check1("t6_start_mc", start_mc_o, 1'b0);
    checkw("t6_info", BW'(mb_type_info_o), '0);
    checkw("t6_fmv", BW'(fmv_o), '0);
    checkw("t6_imv", BW'(imv_o), '0);
    check1("t6_tq_rdy", tq_rdy_o, 1'b0);
    check1("t6_tq_valid", tq_valid_o, 1'b0);
    checkw("t6_tq_data", tq_data_o, '0);
    check1("t6_err", err_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    tick();
    check1("t6_ready_after", mb_ready_o, 1'b1);
    check1("t6_tq_rdy_after", tq_rdy_o, 1'b0);

    // protocol error: out-of-range beat address during RUN
    send_job(5);
    for (int a = 0; a < 6; a++) beat_cycle(5, a, 1'b1, 1'b0);
    check1("t5_err_clean", err_o, 1'b0);
    beat_cycle(98, 12, 1'b1, 1'b0);
    check1("t5_err_addr12", err_o, 1'b1);
    for (int a = 6; a < 12; a++) beat_cycle(5, a, 1'b1, a == 11);
    tick();
    check1("t5_tq_rdy", tq_rdy_o, 1'b1);
    tq_read("t5_rd0", 0, beat(5, 0));
    tq_read("t5_rd11", 11, beat(5, 11));

    // protocol error: beat while IDLE must not reach the bank
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    check1("t5b_err_cleared", err_o, 1'b0);
    beat_cycle(99, 3, 1'b1, 1'b0);
    check1("t5b_err_idle_beat", err_o, 1'b1);
    send_job(6);
    for (int a = 0; a < 12; a++) if (a != 3) beat_cycle(6, a, 1'b1, 1'b0);
    beat_cycle(0, 0, 1'b0, 1'b1);
    wait_tqrdy("t5b_tq_rdy");
    tq_read("t5b_rd3_unchanged", 3, beat(5, 3));
    tq_read("t5b_rd4", 4, beat(6, 4));

    repeat (2) tick();
    checkw("sb_drained", BW'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected to finish");
    $fatal(1, "watchdog");
  end

endmodule
